// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: turns single-beat instruction-fetch reads (req/addr_ok/
// data_ok handshake) into AXI4 AR/R transactions. Only one ID is used, so
// AXI same-ID ordering returns data in issue order without a reorder buffer.
module inst_axi_rd_bridge #(
  parameter logic [3:0] AR_ID = 4'd0,
  parameter int         DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_bus_err,
  output logic [3:0]  axi_arid_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  ar_state_t   state_r;
  ar_state_t   state_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_s;
  logic [31:0] araddr_r;
  logic [1:0]  size_r;
  logic [31:0] rdata_r;
  logic        data_ok_r;
  logic        bus_err_r;
  logic        addr_ok_s;
  logic        arvalid_s;
  logic        rready_s;
  logic        beat_s;
  logic        dec_s;
  logic        unused_s;

  // Write data, strobes and rlast carry no information for single-beat reads.
  assign unused_s = ^{inst_sram_wstrb, inst_sram_wdata, rlast};

  assign rready_s = (cnt_r != 2'd0);
  assign beat_s   = rvalid & rready_s & (rid == AR_ID);
  // Saturating guard keeps the counter from wrapping on a stray extra beat.
  assign dec_s    = data_ok_r & (cnt_r != 2'd0);

  // AR state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= AR_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // AR next-state: leave IDLE on an accepted request, leave SEND on the AR handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      AR_IDLE: begin
        if (addr_ok_s) state_s = AR_SEND;
        else           state_s = AR_IDLE;
      end
      AR_SEND: begin
        if (arready) state_s = AR_IDLE;
        else         state_s = AR_SEND;
      end
      default: state_s = AR_IDLE;
    endcase
  end

  // AR outputs: accept only reads in IDLE with room for another outstanding beat.
  always_comb begin
    addr_ok_s = 1'b0;
    arvalid_s = 1'b0;
    case (state_r)
      AR_IDLE: begin
        if (inst_sram_req && !inst_sram_wr && (cnt_r < DEPTH_C)) addr_ok_s = 1'b1;
        else                                                     addr_ok_s = 1'b0;
      end
      AR_SEND: arvalid_s = 1'b1;
      default: begin
        addr_ok_s = 1'b0;
        arvalid_s = 1'b0;
      end
    endcase
  end

  // Outstanding count: accept adds one, data_ok removes one, both cancel out.
  always_comb begin
    cnt_s = cnt_r;
    case ({addr_ok_s, dec_s})
      2'b10:   cnt_s = cnt_r + 2'd1;
      2'b01:   cnt_s = cnt_r - 2'd1;
      default: cnt_s = cnt_r;
    endcase
  end

  // Counter, request latch and returned-data registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r     <= 2'd0;
      araddr_r  <= 32'd0;
      size_r    <= 2'd0;
      rdata_r   <= 32'd0;
      data_ok_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      data_ok_r <= beat_s;
      bus_err_r <= beat_s & (rresp != 2'b00);
      if (addr_ok_s) begin
        araddr_r <= inst_sram_addr;
        size_r   <= inst_sram_size;
      end
      if (beat_s) begin
        rdata_r <= rdata;
      end
    end
  end

  assign inst_sram_addr_ok = addr_ok_s;
  assign inst_sram_data_ok = data_ok_r;
  assign inst_sram_rdata   = rdata_r;
  assign inst_bus_err      = bus_err_r;
  assign axi_arid_o        = AR_ID;
  assign arid              = AR_ID;
  assign araddr            = araddr_r;
  assign arlen             = 8'd0;
  assign arsize            = {1'b0, size_r};
  assign arburst           = 2'b01;
  assign arlock            = 2'b00;
  assign arcache           = 4'b0000;
  assign arprot            = 3'b000;
  assign arvalid           = arvalid_s;
  assign rready            = rready_s;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: a per-cycle vector table for the
// basic flows plus hand-written sequences for the outstanding limit,
// simultaneous accept/return and reset while AR is pending.
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_bus_err;
  logic [3:0]  axi_arid_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  inst_axi_rd_bridge #(.AR_ID(4'd0), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .inst_bus_err(inst_bus_err),
    .axi_arid_o(axi_arid_o), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        e_addr_ok;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic [2:0]  e_arsize;
    logic        e_rready;
    logic        e_data_ok;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(
    input logic [31:0] req, input logic [31:0] wr, input logic [31:0] size,
    input logic [31:0] addr, input logic [31:0] ardy, input logic [31:0] rv,
    input logic [31:0] id, input logic [31:0] rd, input logic [31:0] rsp,
    input logic [31:0] aok, input logic [31:0] arv, input logic [31:0] ara,
    input logic [31:0] ars, input logic [31:0] rrdy, input logic [31:0] dok,
    input logic [31:0] erd, input logic [31:0] err);
    vec_t v;
    v.req = req[0];       v.wr = wr[0];           v.size = size[1:0];
    v.addr = addr;        v.arready = ardy[0];    v.rvalid = rv[0];
    v.rid = id[3:0];      v.rdata = rd;           v.rresp = rsp[1:0];
    v.e_addr_ok = aok[0]; v.e_arvalid = arv[0];   v.e_araddr = ara;
    v.e_arsize = ars[2:0]; v.e_rready = rrdy[0];  v.e_data_ok = dok[0];
    v.e_rdata = erd;      v.e_err = err[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic ardy,
                       input logic rv, input logic [31:0] rd);
    inst_sram_req  = req;
    inst_sram_wr   = 1'b0;
    inst_sram_size = 2'd2;
    inst_sram_addr = addr;
    arready        = ardy;
    rvalid         = rv;
    rid            = 4'd0;
    rdata          = rd;
    rresp          = 2'b00;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_wstrb = 4'hf;
    inst_sram_wdata = 32'h0;
    rlast = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    tbl[0]  = mk(0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,2,32'h1c000000,1,0,0,0,0,          1,0,0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,1,0,0,0,0,                     0,1,32'h1c000000,2,1,0,0,0);
    tbl[3]  = mk(0,0,0,0,0,1,0,32'h02c00000,0,          0,0,32'h1c000000,2,1,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000000,2,1,1,32'h02c00000,0);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000000,2,0,0,32'h02c00000,0);
    tbl[6]  = mk(1,0,2,32'h1c000004,0,0,0,0,0,          1,0,32'h1c000000,2,0,0,32'h02c00000,0);
    for (int i = 7; i <= 10; i++)
      tbl[i] = mk(1,0,2,32'h1c000008,0,0,0,0,0,         0,1,32'h1c000004,2,1,0,32'h02c00000,0);
    tbl[11] = mk(0,0,0,0,1,0,0,0,0,                     0,1,32'h1c000004,2,1,0,32'h02c00000,0);
    tbl[12] = mk(0,0,0,0,0,1,0,32'h11223344,0,          0,0,32'h1c000004,2,1,0,32'h02c00000,0);
    tbl[13] = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000004,2,1,1,32'h11223344,0);
    tbl[14] = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000004,2,0,0,32'h11223344,0);
    tbl[15] = mk(1,0,0,32'h1c000010,1,0,0,0,0,          1,0,32'h1c000004,2,0,0,32'h11223344,0);
    tbl[16] = mk(0,0,0,0,1,0,0,0,0,                     0,1,32'h1c000010,0,1,0,32'h11223344,0);
    tbl[17] = mk(0,0,0,0,0,1,1,32'hdeadbeef,0,          0,0,32'h1c000010,0,1,0,32'h11223344,0);
    tbl[18] = mk(0,0,0,0,0,1,0,32'hcafef00d,2,          0,0,32'h1c000010,0,1,0,32'h11223344,0);
    tbl[19] = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000010,0,1,1,32'hcafef00d,1);
    tbl[20] = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000010,0,0,0,32'hcafef00d,0);
    tbl[21] = mk(1,1,2,32'h1c000020,1,0,0,0,0,          0,0,32'h1c000010,0,0,0,32'hcafef00d,0);
    tbl[22] = mk(1,1,2,32'h1c000020,1,0,0,0,0,          0,0,32'h1c000010,0,0,0,32'hcafef00d,0);
    tbl[23] = mk(0,0,0,0,0,1,0,32'h55555555,0,          0,0,32'h1c000010,0,0,0,32'hcafef00d,0);
    tbl[24] = mk(0,0,0,0,0,0,0,0,0,                     0,0,32'h1c000010,0,0,0,32'hcafef00d,0);

    // Reset state.
    tick(); tick();
    chk("rst addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("rst data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("rst bus_err", {31'd0, inst_bus_err}, 32'd0);
    chk("rst rdata", inst_sram_rdata, 32'd0);
    chk("rst arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst araddr", araddr, 32'd0);
    chk("rst arsize", {29'd0, arsize}, 32'd0);
    chk("rst rready", {31'd0, rready}, 32'd0);
    chk("const arid", {28'd0, arid}, 32'd0);
    chk("const axi_arid_o", {28'd0, axi_arid_o}, 32'd0);
    chk("const arlen", {24'd0, arlen}, 32'd0);
    chk("const arburst", {30'd0, arburst}, 32'd1);
    chk("const arlock/cache/prot", {23'd0, arlock, arcache, arprot}, 32'd0);
    resetn = 1'b1;

    // Vector table, one row per clock cycle.
    for (int i = 0; i < 25; i++) begin
      tick();
      inst_sram_req  = tbl[i].req;
      inst_sram_wr   = tbl[i].wr;
      inst_sram_size = tbl[i].size;
      inst_sram_addr = tbl[i].addr;
      arready        = tbl[i].arready;
      rvalid         = tbl[i].rvalid;
      rid            = tbl[i].rid;
      rdata          = tbl[i].rdata;
      rresp          = tbl[i].rresp;
      #1;
      chk($sformatf("row%0d addr_ok", i), {31'd0, inst_sram_addr_ok}, {31'd0, tbl[i].e_addr_ok});
      chk($sformatf("row%0d arvalid", i), {31'd0, arvalid}, {31'd0, tbl[i].e_arvalid});
      chk($sformatf("row%0d araddr", i), araddr, tbl[i].e_araddr);
      chk($sformatf("row%0d arsize", i), {29'd0, arsize}, {29'd0, tbl[i].e_arsize});
      chk($sformatf("row%0d rready", i), {31'd0, rready}, {31'd0, tbl[i].e_rready});
      chk($sformatf("row%0d data_ok", i), {31'd0, inst_sram_data_ok}, {31'd0, tbl[i].e_data_ok});
      chk($sformatf("row%0d rdata", i), inst_sram_rdata, tbl[i].e_rdata);
      chk($sformatf("row%0d bus_err", i), {31'd0, inst_bus_err}, {31'd0, tbl[i].e_err});
    end

    // Outstanding limit: third request stalls until the first data_ok.
    tick(); drive(1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h0);
    chk("lim a0 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); drive(1'b1, 32'h1c000104, 1'b1, 1'b0, 32'h0);
    chk("lim a1 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("lim a1 araddr", araddr, 32'h1c000100);
    tick(); drive(1'b1, 32'h1c000104, 1'b1, 1'b0, 32'h0);
    chk("lim a2 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); drive(1'b1, 32'h1c000108, 1'b1, 1'b0, 32'h0);
    chk("lim a3 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("lim a3 araddr", araddr, 32'h1c000104);
    for (int k = 4; k <= 5; k++) begin
      tick(); drive(1'b1, 32'h1c000108, 1'b1, 1'b0, 32'h0);
      chk($sformatf("lim a%0d addr_ok", k), {31'd0, inst_sram_addr_ok}, 32'd0);
      chk($sformatf("lim a%0d arvalid", k), {31'd0, arvalid}, 32'd0);
      chk($sformatf("lim a%0d cnt", k), {30'd0, dut.cnt_r}, 32'd2);
    end
    tick(); drive(1'b1, 32'h1c000108, 1'b1, 1'b1, 32'h0000a000);
    chk("lim a6 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick(); drive(1'b1, 32'h1c000108, 1'b1, 1'b0, 32'h0);
    chk("lim a7 data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("lim a7 rdata", inst_sram_rdata, 32'h0000a000);
    chk("lim a7 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick(); drive(1'b1, 32'h1c000108, 1'b1, 1'b0, 32'h0);
    chk("lim a8 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    chk("lim a8 data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    tick(); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000a001);
    chk("lim a9 araddr", araddr, 32'h1c000108);
    chk("lim a9 arvalid", {31'd0, arvalid}, 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000a002);
    chk("lim a10 data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("lim a10 rdata", inst_sram_rdata, 32'h0000a001);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("lim a11 data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("lim a11 rdata", inst_sram_rdata, 32'h0000a002);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("lim a12 data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("lim a12 rready", {31'd0, rready}, 32'd0);

    // Simultaneous accept and return with one read outstanding.
    tick(); drive(1'b1, 32'h1c000200, 1'b1, 1'b0, 32'h0);
    chk("sim b0 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000b000);
    tick(); drive(1'b1, 32'h1c000204, 1'b1, 1'b0, 32'h0);
    chk("sim b3 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    chk("sim b3 data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("sim b3 cnt", {30'd0, dut.cnt_r}, 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("sim b4 cnt", {30'd0, dut.cnt_r}, 32'd1);
    chk("sim b4 araddr", araddr, 32'h1c000204);
    chk("sim b4 rready", {31'd0, rready}, 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000b001);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("sim b6 data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("sim b6 rdata", inst_sram_rdata, 32'h0000b001);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("sim b7 cnt", {30'd0, dut.cnt_r}, 32'd0);

    // Reset while AR is pending; stale beats afterwards are not consumed.
    tick(); drive(1'b1, 32'h1c000300, 1'b0, 1'b0, 32'h0);
    chk("rst c0 addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst c1 arvalid", {31'd0, arvalid}, 32'd1);
    resetn = 1'b0;
    tick();
    chk("rst c2 arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst c2 rready", {31'd0, rready}, 32'd0);
    chk("rst c2 cnt", {30'd0, dut.cnt_r}, 32'd0);
    chk("rst c2 araddr", araddr, 32'd0);
    resetn = 1'b1;
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000c000);
    chk("rst c3 rready", {31'd0, rready}, 32'd0);
    tick(); drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst c4 data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("rst c4 rdata", inst_sram_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
# inst_axi_rd_bridge

Responder end of the instruction-fetch SRAM-like bus: accepts single-beat read requests from the fetch stage (req/addr_ok/data_ok handshake) and converts them into AXI4 read transactions on the AR/R channels. Sits between the IF stage and the top-level AXI interconnect. It supports up to DEPTH outstanding reads, returns data in issue order, and reports its current ARID back to the fetch stage.

## Interface
- AR_ID, 4'd0, ARID driven on every read issued by this block; R beats with other RID are ignored.
- DEPTH, 2, maximum outstanding accepted-but-not-returned reads (1..3).
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- inst_sram_req  in  1  request valid.
- inst_sram_wr  in  1  write flag; writes are never accepted.
- inst_sram_size  in  2  transfer size (0=byte, 1=half, 2=word).
- inst_sram_addr  in  32  request address.
- inst_sram_wstrb  in  4  ignored.
- inst_sram_wdata  in  32  ignored.
- inst_sram_addr_ok  out  1  request accepted this cycle.
- inst_sram_data_ok  out  1  one-cycle pulse, rdata valid.
- inst_sram_rdata  out  32  returned data.
- inst_bus_err  out  1  pulses with data_ok when the returned RRESP != 0.
- axi_arid_o  out  4  constant AR_ID, fed back to the fetch stage.
- arid  out  4  = AR_ID.
- araddr  out  32  registered request address.
- arlen  out  8  constant 0.
- arsize  out  3  {1'b0, latched size}.
- arburst  out  2  constant 2'b01.
- arlock  out  2  0.
- arcache  out  4  0.
- arprot  out  3  0.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R id.
- rdata  in  32  R data.
- rresp  in  2  R response.
- rlast  in  1  ignored (arlen=0).
- rvalid  in  1  R valid.
- rready  out  1  R ready.

## Operation
- AR FSM, 2 states: AR_IDLE, AR_SEND. Reset: AR_IDLE.
- addr_ok (combinational) = state==AR_IDLE & req & ~wr & cnt<DEPTH.
- On addr_ok: latch addr into araddr and size into arsize[1:0], go to AR_SEND.
- AR_SEND: arvalid=1; araddr/arsize held stable; on arvalid&arready go to AR_IDLE.
- Outstanding counter cnt (2 bits): +1 on addr_ok, -1 on data_ok; both in the same cycle leaves it unchanged. cnt never exceeds DEPTH or underflows.
- rready = (cnt!=0). A beat is accepted when rvalid & rready & rid==AR_ID. A beat with another RID, or a beat while cnt==0, is not consumed by this block.
- Accepted beat: rdata is registered into inst_sram_rdata; data_ok=1 the next cycle for exactly one cycle; inst_bus_err=(rresp!=0) in that same cycle. Data is still delivered on error.
- Requests with wr=1 are never accepted: addr_ok stays 0 and no AXI activity occurs.
- Responses come back in issue order (single ID, AXI same-ID ordering). No reordering buffer is needed.

## Timing
- Reset values: addr_ok 0, data_ok 0, inst_bus_err 0, inst_sram_rdata 0, arvalid 0, araddr 0, arsize 0, rready 0, cnt 0.
- addr_ok is combinational in the request cycle T. arvalid rises at T+1.
- Best case, with arready=1 at T+1 and R beat at T+2: data_ok at T+3. Minimum latency from addr_ok to data_ok is 3 cycles.
- Issue rate is at most 1 request per 2 cycles (AR_SEND occupies one cycle minimum). The next addr_ok is possible at T+2.
- arvalid is never dropped before arready; araddr is constant while arvalid=1.
- The fetch stage may drop req at any time; there is no effect unless addr_ok was asserted.
- Reset mid-transaction: synchronous clear of all state. AXI beats for pre-reset reads arriving after reset are not consumed (cnt==0 forces rready=0).

## Test plan
- Single read: req addr=0x1c000000 size=2, arready=1 immediately, R beat next cycle with rdata=0x02c00000 -> addr_ok at T, arvalid at T+1 with araddr=0x1c000000 arsize=3'b010, data_ok at T+3 with rdata=0x02c00000, cnt back to 0.
- AR backpressure: arready held 0 for 4 cycles -> arvalid stays 1 and araddr stays 0x1c000004 for 5 cycles, no addr_ok during AR_SEND, data_ok exactly one cycle.
- Outstanding limit DEPTH=2: three back-to-back reqs with no R beats -> two addr_ok pulses, third req stalls (addr_ok=0) until the first data_ok, then is accepted; three data_ok pulses in issue order.
- Simultaneous accept and return: addr_ok and data_ok in the same cycle with cnt=1 -> cnt stays 1.
- Error and foreign ID: R beat rid=4'd1 -> ignored, no data_ok. R beat rid=AR_ID rresp=2'b10 -> data_ok and inst_bus_err pulse together.
- Write request and reset: req with wr=1 -> addr_ok never asserts. Assert resetn=0 while in AR_SEND -> next cycle arvalid=0, rready=0, cnt=0.
